// File: rtl/mem_sdp_clr.sv
// Simple-dual-port synchronous RAM with a built-in clear sweep that fills
// every word with CLR_VAL after reset and on request, plus 1- or 2-stage reads.
module mem_sdp_clr #(
    parameter int              DW      = 8,
    parameter int              AW      = 9,
    parameter int              RDLAT   = 1,
    parameter int              BYPASS  = 1,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rdaddr,
    input  logic          re,
    output logic [DW-1:0] dataout,
    output logic          rvalid,
    input  logic [AW-1:0] wraddr,
    input  logic [DW-1:0] datain,
    input  logic          we,
    input  logic          clr,
    output logic          busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    logic [DW-1:0] mem [2**AW];

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic          rd_en;
    logic          hit;

    logic [DW-1:0] data_p1;
    logic          vld_p1;

    // Same-address read-during-write: pick fresh write data or stored word.
    function automatic logic [DW-1:0] rd_sel(input logic [DW-1:0] stored,
                                             input logic [DW-1:0] fresh,
                                             input logic          same);
        return (BYPASS != 0 && same) ? fresh : stored;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR) state_nxt = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy = (state == CLEAR);

    // The sweep owns the write port while busy; nothing is written on a reset edge.
    assign mem_we = !rst && (busy || we);
    assign mem_wa = busy ? cnt : wraddr;
    assign mem_wd = busy ? CLR_VAL : datain;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign rd_en = re && !busy;
    assign hit   = we && (wraddr == rdaddr);

    // Stage 1: array read
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) data_p1 <= rd_sel(mem[rdaddr], datain, hit);
        end
    end

    generate
        if (RDLAT == 1) begin : g_lat1
            assign dataout = data_p1;
            assign rvalid  = vld_p1;
        end else if (RDLAT == 2) begin : g_lat2
            logic [DW-1:0] data_p2;
            logic          vld_p2;

            // Stage 2: output register, holds unless a valid word arrives
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_p2 <= '0;
                    vld_p2  <= 1'b0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) data_p2 <= data_p1;
                end
            end

            assign dataout = data_p2;
            assign rvalid  = vld_p2;
        end else begin : g_bad_lat
            $error("mem_sdp_clr: RDLAT must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_mem_sdp_clr.sv
// Bench for mem_sdp_clr: two instances (RDLAT=1/BYPASS=1/CLR 0x00 and
// RDLAT=2/BYPASS=0/CLR 0xFF) share stimulus and are compared to a word-level model.
module tb_mem_sdp_clr;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] rdaddr;
    logic       re;
    logic [8:0] wraddr;
    logic [7:0] datain;
    logic       we;
    logic       clr;

    logic [7:0] dout1, dout2;
    logic       rv1, rv2, busy1, busy2;

    int checks   = 0;
    int failures = 0;

    // Model: word arrays per instance, remaining sweep cycles, expected outputs.
    logic [7:0] m0 [512];
    logic [7:0] m1 [512];
    int         bl = 0;
    logic [7:0] exp_d1 = 8'h00, exp_d2 = 8'h00, pd = 8'h00;
    logic       exp_v1 = 1'b0, exp_v2 = 1'b0, pv = 1'b0;

    always #5 clk = ~clk;

    mem_sdp_clr #(.DW(8), .AW(9), .RDLAT(1), .BYPASS(1), .CLR_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .rdaddr(rdaddr), .re(re), .dataout(dout1), .rvalid(rv1),
        .wraddr(wraddr), .datain(datain), .we(we), .clr(clr), .busy(busy1)
    );

    mem_sdp_clr #(.DW(8), .AW(9), .RDLAT(2), .BYPASS(0), .CLR_VAL(8'hFF)) dut_b (
        .clk(clk), .rst(rst), .rdaddr(rdaddr), .re(re), .dataout(dout2), .rvalid(rv2),
        .wraddr(wraddr), .datain(datain), .we(we), .clr(clr), .busy(busy2)
    );

    task automatic drive(input logic w, input logic [8:0] wa, input logic [7:0] d,
                         input logic r, input logic [8:0] ra, input logic c);
        we = w; wraddr = wa; datain = d; re = r; rdaddr = ra; clr = c;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        if (rst) begin
            bl = 512;
            exp_d1 = 8'h00; exp_v1 = 1'b0;
            exp_d2 = 8'h00; exp_v2 = 1'b0;
            pv = 1'b0;
        end else begin
            exp_v2 = pv;
            if (pv) exp_d2 = pd;
            if (bl > 0) begin
                m0[512-bl] = 8'h00;
                m1[512-bl] = 8'hFF;
                bl = bl - 1;
                exp_v1 = 1'b0;
                pv = 1'b0;
            end else begin
                pv = re;
                exp_v1 = re;
                if (re) begin
                    exp_d1 = (we && wraddr == rdaddr) ? datain : m0[rdaddr];
                    pd = m1[rdaddr];
                end
                if (we) begin
                    m0[wraddr] = datain;
                    m1[wraddr] = datain;
                end
                if (clr) bl = 512;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        checks++;
        if (dout1 !== 8'h00 || rv1 !== 1'b0 || dout2 !== 8'h00 || rv2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got d1=%h v1=%b d2=%h v2=%b, want 00 0 00 0",
                     dout1, rv1, dout2, rv2);
        end
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy: got %b %b, want 1 1", busy1, busy2);
        end
        rst = 1'b0;
        n = 0;
        bad = 0;
        while (busy1 === 1'b1 && n < 600) begin
            // User traffic during the sweep must be ignored.
            if (n == 100) drive(1, 9'h005, 8'h77, 1, 9'h005, 1);
            else          drive(0, 0, 0, 1, 9'(n), 0);
            tick();
            n++;
            if (rv1 !== 1'b0 || rv2 !== 1'b0) bad++;
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (n != 512) begin
            failures++;
            $display("FAIL reset_sweep_len: busy lasted %0d cycles, want 512", n);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sweep_rvalid: rvalid high %0d times during sweep, want 0", bad);
        end
        for (int i = 0; i <= 512; i++) begin
            if (i < 512) drive(0, 0, 0, 1, 9'(i), 0);
            else         drive(0, 0, 0, 0, 0, 0);
            tick();
            if (i < 512) begin
                checks++;
                if (dout1 !== 8'h00 || rv1 !== 1'b1) begin
                    failures++;
                    $display("FAIL clear0_read[%0d]: got %h/%b, want 00/1", i, dout1, rv1);
                end
            end
            if (i > 0) begin
                checks++;
                if (dout2 !== 8'hFF || rv2 !== 1'b1) begin
                    failures++;
                    $display("FAIL clearFF_read[%0d]: got %h/%b, want ff/1", i - 1, dout2, rv2);
                end
            end
        end
    endtask

    task automatic test_basic_rw();
        drive(1, 9'h010, 8'hA5, 0, 0, 0); tick();
        drive(1, 9'h1FF, 8'h3C, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 9'h010, 0);     tick();
        checks++;
        if (dout1 !== 8'hA5 || rv1 !== 1'b1) begin
            failures++;
            $display("FAIL basic_rd0: got %h/%b, want a5/1", dout1, rv1);
        end
        drive(0, 0, 0, 1, 9'h1FF, 0); tick();
        checks++;
        if (dout1 !== 8'h3C || rv1 !== 1'b1 || dout2 !== 8'hA5 || rv2 !== 1'b1) begin
            failures++;
            $display("FAIL basic_rd1: got a=%h/%b b=%h/%b, want 3c/1 a5/1", dout1, rv1, dout2, rv2);
        end
        drive(0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (dout1 !== 8'h3C || rv1 !== 1'b0 || dout2 !== 8'h3C || rv2 !== 1'b1) begin
            failures++;
            $display("FAIL basic_hold: got a=%h/%b b=%h/%b, want 3c/0 3c/1", dout1, rv1, dout2, rv2);
        end
        tick();
        checks++;
        if (dout2 !== 8'h3C || rv2 !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold_b: got %h/%b, want 3c/0", dout2, rv2);
        end
    endtask

    task automatic test_stream_lat2();
        int bad;
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 8'(i * 8'h11);
            drive(1, 9'(i), v, 0, 0, 0);
            tick();
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(0, 0, 0, 1, 9'(k), 0);
            else       drive(0, 0, 0, 0, 0, 0);
            tick();
            if (k >= 1 && k <= 8) begin
                v = 8'((k - 1) * 8'h11);
                if (dout2 !== v || rv2 !== 1'b1) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stream_lat2: %0d words wrong or rvalid gaps, want 0", bad);
        end
        checks++;
        if (dout2 !== 8'h77 || rv2 !== 1'b0) begin
            failures++;
            $display("FAIL stream_hold: got %h/%b, want 77/0", dout2, rv2);
        end
    endtask

    task automatic test_collision();
        drive(1, 9'h020, 8'h55, 0, 0, 0);        tick();
        drive(1, 9'h020, 8'hAA, 1, 9'h020, 0);   tick();
        checks++;
        if (dout1 !== 8'hAA || rv1 !== 1'b1) begin
            failures++;
            $display("FAIL coll_bypass: got %h/%b, want aa/1", dout1, rv1);
        end
        drive(0, 0, 0, 1, 9'h020, 0); tick();
        checks++;
        if (dout2 !== 8'h55 || rv2 !== 1'b1) begin
            failures++;
            $display("FAIL coll_old: got %h/%b, want 55/1", dout2, rv2);
        end
        checks++;
        if (dout1 !== 8'hAA) begin
            failures++;
            $display("FAIL coll_after_a: got %h, want aa", dout1);
        end
        drive(0, 0, 0, 0, 0, 0); tick();
        checks++;
        if (dout2 !== 8'hAA || rv2 !== 1'b1) begin
            failures++;
            $display("FAIL coll_after_b: got %h/%b, want aa/1", dout2, rv2);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 8'($urandom),
                  1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 0);
            tick();
            checks++;
            if (dout1 !== exp_d1 || rv1 !== exp_v1 || dout2 !== exp_d2 || rv2 !== exp_v2) begin
                failures++;
                bad++;
                if (bad < 8)
                    $display("FAIL random[%0d]: got a=%h/%b b=%h/%b, want a=%h/%b b=%h/%b",
                             i, dout1, rv1, dout2, rv2, exp_d1, exp_v1, exp_d2, exp_v2);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_clr();
        logic [7:0] old;
        int n;
        for (int i = 0; i < 512; i++) begin
            drive(1, 9'(i), 8'($urandom), 0, 0, 0);
            tick();
        end
        old = m0[5];
        drive(0, 0, 0, 1, 9'h005, 1);
        tick();
        checks++;
        if (dout1 !== old || rv1 !== 1'b1 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL clr_edge_read_a: got %h/%b busy=%b, want %h/1 busy=1", dout1, rv1, busy1, old);
        end
        drive(0, 0, 0, 1, 9'h006, 0);
        tick();
        checks++;
        if (dout2 !== old || rv2 !== 1'b1 || rv1 !== 1'b0) begin
            failures++;
            $display("FAIL clr_edge_read_b: got %h/%b rv_a=%b, want %h/1 rv_a=0", dout2, rv2, rv1, old);
        end
        n = 2;
        while (busy1 === 1'b1 && n < 600) begin
            tick();
            n++;
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (n != 513 || busy2 !== 1'b0 || bl != 0) begin
            failures++;
            $display("FAIL clr_sweep_len: busy lasted %0d cycles, want 512", n - 1);
        end
        for (int i = 0; i <= 512; i++) begin
            if (i < 512) drive(0, 0, 0, 1, 9'(i), 0);
            else         drive(0, 0, 0, 0, 0, 0);
            tick();
            checks++;
            if (dout1 !== exp_d1 || rv1 !== exp_v1 || dout2 !== exp_d2 || rv2 !== exp_v2) begin
                failures++;
                $display("FAIL clr_read[%0d]: got a=%h/%b b=%h/%b, want a=%h/%b b=%h/%b",
                         i, dout1, rv1, dout2, rv2, exp_d1, exp_v1, exp_d2, exp_v2);
            end
        end
        checks++;
        if (exp_d2 !== 8'hFF || dout2 !== 8'hFF) begin
            failures++;
            $display("FAIL clr_value: got %h, want ff", dout2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        drive(0, 0, 0, 1, 9'h003, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 199; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (dout1 !== 8'h00 || rv1 !== 1'b0 || dout2 !== 8'h00 || rv2 !== 1'b0 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_outputs: got a=%h/%b b=%h/%b busy=%b, want 00/0 00/0 busy=1",
                     dout1, rv1, dout2, rv2, busy1);
        end
        rst = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (n != 512) begin
            failures++;
            $display("FAIL midrst_sweep_len: busy lasted %0d cycles, want 512", n);
        end
        drive(0, 0, 0, 1, 9'h1F0, 0);
        tick();
        checks++;
        if (dout1 !== 8'h00 || rv1 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_read: got %h/%b, want 00/1", dout1, rv1);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (dout2 !== 8'hFF || rv2 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_read_b: got %h/%b, want ff/1", dout2, rv2);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++) begin
            m0[i] = 8'h00;
            m1[i] = 8'h00;
        end
        #2;
        test_reset();
        test_basic_rw();
        test_stream_lat2();
        test_collision();
        test_random();
        test_clr();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
